// File: rtl/sccomp_uart_tx_if.sv
// Data-bus bundle between the CPU store/load path and the UART transmitter.
interface sccomp_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, output wdata, output wmem, input rdata, input hit);
  modport slave  (input addr, input wdata, input wmem, output rdata, output hit);
endinterface

// File: rtl/sccomp_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR register window,
// byte FIFO, and a baud-rate state machine driving txd LSB first.
module sccomp_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic             clock,
  input  logic             resetn,
  sccomp_uart_tx_if.slave  bus,
  output logic             txd,
  output logic             busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   div, bit_cnt, bit_cnt_n, eff_div;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    count4;
  logic          overflow;
  logic          full, empty, pop, push, push_req;
  logic          we, sel_data, sel_stat, sel_div;
  logic          unused;

  assign unused = ^{bus.addr[1:0], bus.wdata[31:16]};

  // Address decode and write strobes.
  always_comb begin
    bus.hit  = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[3:2] != 2'b11);
    sel_data = bus.hit && (bus.addr[3:2] == 2'b00);
    sel_stat = bus.hit && (bus.addr[3:2] == 2'b01);
    sel_div  = bus.hit && (bus.addr[3:2] == 2'b10);
    we       = bus.wmem && bus.hit;
    push_req = we && sel_data;
    full     = (count == CW'(FIFO_DEPTH));
    empty    = (count == '0);
    push     = push_req && !full;
    eff_div  = (div == '0) ? 16'd1 : div;
    count4   = 4'(count);
    busy     = (state != IDLE) || !empty;
  end

  // Combinational register read-back.
  always_comb begin
    bus.rdata = '0;
    if (sel_stat)
      bus.rdata = {24'b0, count4, overflow, (state != IDLE), empty, full};
    else if (sel_div)
      bus.rdata = {16'b0, div};
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end

  // FIFO pointers, occupancy, sticky overflow and divisor register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      // Set has priority over a same-edge clear.
      if (push_req && full)                      overflow <= 1'b1;
      else if (we && sel_stat && bus.wdata[3])   overflow <= 1'b0;
      if (we && sel_div) div <= bus.wdata[15:0];
    end
  end

  // Transmit FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Next-state logic; every bit start reloads the timer from the live divisor.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt - 16'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    txd       = 1'b1;
    unique case (state)
      IDLE: begin
        bit_cnt_n = bit_cnt;
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          bit_cnt_n = eff_div;
          state_n   = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_cnt == 16'd1) begin
          bit_cnt_n = eff_div;
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        txd = shift[0];
        if (bit_cnt == 16'd1) begin
          bit_cnt_n = eff_div;
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == 16'd1) begin
          bit_cnt_n = eff_div;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sccomp_uart_tx.sv
// Directed testbench for sccomp_uart_tx: register map, frame timing,
// back-to-back frames, FIFO overflow, zero divisor and mid-frame reset.
module tb_sccomp_uart_tx;
  localparam logic [31:0] A_TX   = 32'h0000_FF00;
  localparam logic [31:0] A_STAT = 32'h0000_FF04;
  localparam logic [31:0] A_DIV  = 32'h0000_FF08;

  logic clock, resetn, txd, busy;
  int   n_vec, n_err;

  sccomp_uart_tx_if bus();

  sccomp_uart_tx #(
    .BASE_ADDR  (32'h0000_FF00),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave),
    .txd   (txd),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.addr  = a;
    bus.wdata = d;
    bus.wmem  = 1'b1;
    @(posedge clock);
    #1 bus.wmem = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    bus.addr = A_STAT; bus.wdata = '0; bus.wmem = 1'b0;
    resetn = 1'b0;
    #12;
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h2) begin n_err++; $display("FAIL reset_status: got %h expected 00000002", bus.rdata); end
    bus.addr = A_DIV; #1;
    n_vec++; if (bus.rdata !== 32'd434) begin n_err++; $display("FAIL reset_div: got %0d expected 434", bus.rdata); end
    bus.addr = 32'h0000_FF0C; #1;
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL hit_ff0c: got %b expected 0", bus.hit); end
    n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rdata_nohit: got %h expected 0", bus.rdata); end
    bus.addr = 32'h0001_FF04; #1;
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL hit_other_base: got %b expected 0", bus.hit); end
    bus.addr = 32'h0000_FF07; #1;
    n_vec++; if (bus.rdata !== 32'h2 || bus.hit !== 1'b1) begin n_err++; $display("FAIL status_low_bits_ignored: got %h/%b expected 00000002/1", bus.rdata, bus.hit); end
    bus.addr = A_TX; #1;
    n_vec++; if (bus.rdata !== 32'h0 || bus.hit !== 1'b1) begin n_err++; $display("FAIL txdata_read: got %h/%b expected 0/1", bus.rdata, bus.hit); end
  endtask

  task automatic test_frame_a5();
    logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'h0000_00A5);
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h10) begin n_err++; $display("FAIL a5_status_after_push: got %h expected 00000010", bus.rdata); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL a5_busy_after_push: got %b expected 1", busy); end
    @(posedge clock);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n_vec++; if (txd !== f[i/4]) begin n_err++; $display("FAIL a5_txd cycle %0d: got %b expected %b", i, txd, f[i/4]); end
      if (i == 39) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL a5_busy_in_stop: got %b expected 1", busy); end
      end
    end
    @(negedge clock);
    n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL a5_end: got busy=%b txd=%b expected 0/1", busy, txd); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] f;
    int b;
    bus_write(A_DIV, 32'd2);
    bus_write(A_TX, 32'h01);
    bus_write(A_TX, 32'h02);
    n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL b2b_first_start: got %b expected 0", txd); end
    bus_write(A_TX, 32'h03);
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h24) begin n_err++; $display("FAIL b2b_status_count: got %h expected 00000024", bus.rdata); end
    for (int i = 1; i < 60; i++) begin
      @(negedge clock);
      b = i / 20;
      f = {1'b1, 8'(b + 1), 1'b0};
      n_vec++; if (txd !== f[(i % 20) / 2]) begin n_err++; $display("FAIL b2b_txd cycle %0d: got %b expected %b", i, txd, f[(i % 20) / 2]); end
    end
    @(negedge clock);
    n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL b2b_end: got busy=%b txd=%b expected 0/1", busy, txd); end
  endtask

  task automatic test_overflow();
    bus_write(A_DIV, 32'd1000);
    for (int i = 0; i < 10; i++) bus_write(A_TX, 32'(i));
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h8D) begin n_err++; $display("FAIL ovf_status: got %h expected 0000008d", bus.rdata); end
    bus_write(A_STAT, 32'hFFFF_FFF7);
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h8D) begin n_err++; $display("FAIL ovf_no_clear: got %h expected 0000008d", bus.rdata); end
    bus_write(A_STAT, 32'h8);
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h85) begin n_err++; $display("FAIL ovf_clear: got %h expected 00000085", bus.rdata); end
    bus.addr = A_DIV; #1;
    n_vec++; if (bus.rdata !== 32'd1000) begin n_err++; $display("FAIL ovf_div: got %0d expected 1000", bus.rdata); end
    do_reset();
  endtask

  task automatic test_div_zero();
    bus_write(A_DIV, 32'd0);
    bus.addr = A_DIV; #1;
    n_vec++; if (bus.rdata !== 32'd0) begin n_err++; $display("FAIL div0_read: got %0d expected 0", bus.rdata); end
    bus_write(A_TX, 32'hFF);
    @(posedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_vec++; if (txd !== (i != 0)) begin n_err++; $display("FAIL div0_txd cycle %0d: got %b expected %b", i, txd, (i != 0)); end
      if (i == 9) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL div0_busy_in_stop: got %b expected 1", busy); end
      end
    end
    @(negedge clock);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL div0_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'h00);
    @(posedge clock);
    repeat (10) @(negedge clock);
    n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL midrst_data_bit: got %b expected 0", txd); end
    resetn = 1'b0; #1;
    n_vec++; if (txd !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_immediate: got txd=%b busy=%b expected 1/0", txd, busy); end
    @(negedge clock); resetn = 1'b1;
    bus.addr = A_STAT; #1;
    n_vec++; if (bus.rdata !== 32'h2) begin n_err++; $display("FAIL midrst_status: got %h expected 00000002", bus.rdata); end
    bus.addr = A_DIV; #1;
    n_vec++; if (bus.rdata !== 32'd434) begin n_err++; $display("FAIL midrst_div: got %0d expected 434", bus.rdata); end
    repeat (6) @(negedge clock);
    n_vec++; if (txd !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_stays_idle: got txd=%b busy=%b expected 1/0", txd, busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_overflow();
    test_div_zero();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sccomp_uart_tx.md
# sccomp_uart_tx

Memory-mapped UART transmitter on the single-cycle SoC data bus, downstream of the CPU store path. It decodes CPU stores (address = ALU result, store data, write enable) in a small register window and queues bytes in a FIFO. A baud-rate state machine serialises them 8N1, LSB first, on `txd`. Combinational status reads let the SoC mux `rdata` into the CPU's memory-read path when `hit` is asserted.

## Interface
- `BASE_ADDR`, 32'h0000_FF00: window base; must be 16-byte aligned.
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two, 2..8.
- `DEFAULT_DIV`, 16'd434: clocks per bit after reset.
- `clock`  in  1: system clock, the same clock as the CPU; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `addr`  in  32: CPU data address.
- `wdata`  in  32: CPU store data.
- `wmem`  in  1: CPU store enable.
- `rdata`  out  32: read data for `addr`, combinational.
- `hit`  out  1: `addr` selects a register of this block, combinational.
- `txd`  out  1: serial output, idle high.
- `busy`  out  1: FSM not IDLE, or FIFO non-empty.

## Operation
- Register map, word offsets from `BASE_ADDR`:
  - 0x0 TXDATA: a write pushes `wdata[7:0]`; reads return 0.
  - 0x4 STATUS: read-only except bit 3.
    - [0] full, [1] empty, [2] FSM not IDLE, [3] overflow (sticky), [7:4] FIFO count, [31:8] 0.
    - Writing with `wdata[3]`=1 clears overflow; other bits are ignored.
  - 0x8 DIVISOR: reads `{16'b0, div}`; a write loads `wdata[15:0]`.
- `hit` = (`addr[31:4]`==`BASE_ADDR[31:4]`) && (`addr[3:2]`!=2'b11). When `hit`=0, `rdata`=0. `addr[1:0]` is ignored.
- Write strobe: `wmem && hit` at a rising edge.
- FIFO:
  - Circular buffer with read/write pointers and a count of `$clog2(FIFO_DEPTH)+1` bits.
  - A push while full (count as of before the edge) is dropped and sets overflow, even if a pop happens at the same edge.
  - Push and pop at the same edge when not full: both happen, count unchanged.
- Effective divisor = `div`, except 0 is treated as 1.
- FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty: pop into the shift register, load the bit counter with the effective divisor, go to START.
  - START: `txd`=0 for one bit time, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for one bit time, shift right, index+1. After index 7 completes, go to STOP.
  - STOP: `txd`=1 for one bit time. At its end:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Bit time: a down-counter loaded with the effective divisor at each bit start. The bit ends on the edge where the counter equals 1.
- A DIVISOR write mid-frame affects only bits that start after the write edge.
- Clearing overflow at the same edge as an overflowing push leaves overflow set (set wins).

## Timing
- Reset values (asynchronous, immediate on `resetn`=0):
  - `txd`=1, state IDLE, FIFO empty, pointers 0, overflow 0, `div`=`DEFAULT_DIV`, shift register 0, `busy`=0.
- Reset mid-frame aborts the frame: `txd` returns high immediately and queued bytes are lost.
- TXDATA write captured at edge E0:
  - count=1 and `busy`=1 after E0.
  - At E1 the FSM pops and `txd` falls; it stays low for D cycles, where D = effective divisor.
- Frame length is exactly 10·D cycles.
- Back-to-back queued bytes: the next start bit begins on the edge that ends the previous stop bit.
- `busy` falls on the edge ending the last stop bit, when the FIFO is empty.
- STATUS reads reflect register state after the most recent edge. There is no read side effect.

## Test plan
- Reset, then read STATUS → 0x0000_0002. Read DIVISOR → 434. `txd`=1, `hit`=0 for addr 0x0000_FF0C.
- DIVISOR←4, then TXDATA←0xA5 → `txd` from E1: 0 ×4 cycles, then bits 1,0,1,0,0,1,0,1 ×4 each, then 1 ×4. `busy` drops at E1+40.
- DIVISOR←2, then 3 consecutive TXDATA writes 0x01, 0x02, 0x03 → three contiguous 20-cycle frames with no idle cycles. STATUS count reads 2 right after the first pop.
- DIVISOR←1000, then 10 TXDATA writes in consecutive cycles:
  - Write 1 is popped at the next edge, 8 fill the FIFO, write 10 is dropped.
  - STATUS → full=1, overflow=1, count=8.
  - Write STATUS←0x8 → overflow=0.
- DIVISOR←0, then TXDATA←0xFF → 10-cycle frame (divisor treated as 1).
- Mid-frame (during DATA) assert `resetn`=0 for one cycle → `txd`=1 immediately. STATUS → 0x0000_0002. `div`=434.
